// File: rtl/triage_pkg.sv
// Shared constants, width helpers and the slot layout for the triage priority queue.
package triage_pkg;

  localparam int DEF_ID_W       = 2;
  localparam int DEF_PRIO_W     = 2;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_WAIT_W     = 8;
  localparam int DEF_AGE_PERIOD = 16;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of the aging timer; at least one bit so aging-off builds still elaborate.
  function automatic int tmr_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  localparam int DEF_TMR_W = (DEF_AGE_PERIOD > 1) ? $clog2(DEF_AGE_PERIOD) : 1;

  // Slot layout in the default configuration; the top builds the same layout
  // from its own parameters.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_PRIO_W-1:0] prio;
    logic [DEF_WAIT_W-1:0] wait_cnt;
    logic [DEF_TMR_W-1:0]  age_tmr;
  } entry_t;

endpackage

// File: rtl/triage_select.sv
// Combinational argmax over the slots: highest prio, then longest wait, then lowest index.
module triage_select
  import triage_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PRIO_W = DEF_PRIO_W,
  parameter int WAIT_W = DEF_WAIT_W,
  parameter int IDX_W  = $clog2(DEF_DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [PRIO_W-1:0] prio     [DEPTH],
  input  logic [WAIT_W-1:0] wait_cnt [DEPTH],
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [PRIO_W-1:0] best_prio;
  logic [WAIT_W-1:0] best_wait;

  // Linear scan; strict comparisons keep the lower index on a full tie.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    best_prio = '0;
    best_wait = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (!hit || (prio[i] > best_prio) ||
                       ((prio[i] == best_prio) && (wait_cnt[i] > best_wait)))) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        best_prio = prio[i];
        best_wait = wait_cnt[i];
      end
    end
  end

endmodule

// File: rtl/triage_pqueue.sv
// Patient priority queue: valid/ready admission, one-cycle-latency release of the
// most urgent patient, first-come tie-break and periodic priority aging.
//
// Handshake: a patient is admitted on a rising edge where enq_valid && enq_ready;
// enq_valid while enq_ready is low discards the patient and pulses drop next cycle.
// A doctor request (deq_req) is honoured on any edge where the queue is non-empty;
// the released patient appears on deq_id/deq_prio with a one-cycle deq_valid pulse
// in the following cycle. There is no back-pressure on the release side.
module triage_pqueue
  import triage_pkg::*;
#(
  parameter int ID_W       = DEF_ID_W,
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WAIT_W     = DEF_WAIT_W,
  parameter int AGE_PERIOD = DEF_AGE_PERIOD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_valid,
  input  logic [ID_W-1:0]               enq_id,
  input  logic [PRIO_W-1:0]             enq_prio,
  output logic                          enq_ready,
  input  logic                          deq_req,
  output logic                          deq_valid,
  output logic [ID_W-1:0]               deq_id,
  output logic [PRIO_W-1:0]             deq_prio,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          drop
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = tmr_width(AGE_PERIOD);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] prio;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMR_W-1:0]  age_tmr;
  } slot_t;

  slot_t             slots    [DEPTH];
  slot_t             slots_nx [DEPTH];
  logic [DEPTH-1:0]  sel_valid;
  logic [PRIO_W-1:0] sel_prio [DEPTH];
  logic [WAIT_W-1:0] sel_wait [DEPTH];
  logic [IDX_W-1:0]  win_idx;
  logic              win_hit;
  logic [IDX_W-1:0]  free_idx;
  logic              enq_fire;
  logic              deq_fire;

  assign enq_ready = (count < CNT_W'(DEPTH));
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_fire  = enq_valid && enq_ready;
  // win_hit is set exactly when some slot is valid, i.e. when the queue is non-empty.
  assign deq_fire  = deq_req && win_hit;

  // Present the pre-edge slot contents to the selector.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel_valid[i] = slots[i].valid;
      sel_prio[i]  = slots[i].prio;
      sel_wait[i]  = slots[i].wait_cnt;
    end
  end

  triage_select #(
    .DEPTH  (DEPTH),
    .PRIO_W (PRIO_W),
    .WAIT_W (WAIT_W),
    .IDX_W  (IDX_W)
  ) u_select (
    .valid    (sel_valid),
    .prio     (sel_prio),
    .wait_cnt (sel_wait),
    .idx      (win_idx),
    .hit      (win_hit)
  );

  // Lowest free slot, counting the slot released by this cycle's dequeue as free.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slots[i].valid || (deq_fire && (win_idx == IDX_W'(i)))) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Per-slot next state: age waiting patients, then apply release, then admission.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slots_nx[i] = slots[i];
      if (slots[i].valid) begin
        if (slots[i].wait_cnt != '1) begin
          slots_nx[i].wait_cnt = slots[i].wait_cnt + 1'b1;
        end
        if (AGE_PERIOD > 0) begin
          if (slots[i].age_tmr == TMR_W'(AGE_PERIOD - 1)) begin
            slots_nx[i].age_tmr = '0;
            if (slots[i].prio != '1) begin
              slots_nx[i].prio = slots[i].prio + 1'b1;
            end
          end else begin
            slots_nx[i].age_tmr = slots[i].age_tmr + 1'b1;
          end
        end
      end
      if (deq_fire && (win_idx == IDX_W'(i))) begin
        slots_nx[i].valid = 1'b0;
      end
      if (enq_fire && (free_idx == IDX_W'(i))) begin
        slots_nx[i].valid    = 1'b1;
        slots_nx[i].id       = enq_id;
        slots_nx[i].prio     = enq_prio;
        slots_nx[i].wait_cnt = '0;
        slots_nx[i].age_tmr  = '0;
      end
    end
  end

  // Slot storage and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= slots_nx[i];
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered release and drop pulses; the released ID/prio hold between releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deq_valid <= 1'b0;
      deq_id    <= '0;
      deq_prio  <= '0;
      drop      <= 1'b0;
    end else begin
      deq_valid <= deq_fire;
      drop      <= enq_valid && !enq_ready;
      if (deq_fire) begin
        deq_id   <= slots[win_idx].id;
        deq_prio <= slots[win_idx].prio;
      end
    end
  end

endmodule

// File: tb/tb_triage_pqueue.sv
// Directed bench for triage_pqueue: a default-parameter instance plus a fast-aging
// instance (AGE_PERIOD = 4); releases are scoreboarded by a negedge monitor.
module tb_triage_pqueue;

  localparam int W = 20; // {id[1:0], prio[1:0], due_cycle[15:0]}

  logic        clk;
  logic        rst;
  logic [15:0] cyc = '0;

  // default instance
  logic       enq_valid, deq_req;
  logic [1:0] enq_id, enq_prio;
  logic       enq_ready, deq_valid, full, empty, drop;
  logic [1:0] deq_id, deq_prio;
  logic [2:0] count;

  // fast-aging instance
  logic       a_enq_valid, a_deq_req;
  logic [1:0] a_enq_id, a_enq_prio;
  logic       a_enq_ready, a_deq_valid, a_full, a_empty, a_drop;
  logic [1:0] a_deq_id, a_deq_prio;
  logic [2:0] a_count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] age_q[$];
  logic [W-1:0] m_exp;
  int total = 0;
  int bad = 0;
  int drop_seen = 0;

  triage_pqueue u_dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_id    (enq_id),
    .enq_prio  (enq_prio),
    .enq_ready (enq_ready),
    .deq_req   (deq_req),
    .deq_valid (deq_valid),
    .deq_id    (deq_id),
    .deq_prio  (deq_prio),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  triage_pqueue #(.AGE_PERIOD(4)) u_age (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (a_enq_valid),
    .enq_id    (a_enq_id),
    .enq_prio  (a_enq_prio),
    .enq_ready (a_enq_ready),
    .deq_req   (a_deq_req),
    .deq_valid (a_deq_valid),
    .deq_id    (a_deq_id),
    .deq_prio  (a_deq_prio),
    .count     (a_count),
    .full      (a_full),
    .empty     (a_empty),
    .drop      (a_drop)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  // monitor: pop and compare on every release pulse, count drop pulses
  always @(negedge clk) begin
    if (deq_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL deq_unexpected: got id=%0d prio=%0d at cycle %0d, want no release", deq_id, deq_prio, cyc);
      end else begin
        m_exp = exp_q.pop_front();
        if ({deq_id, deq_prio, cyc} !== m_exp) begin
          bad++;
          $display("FAIL deq_release: got id=%0d prio=%0d cycle=%0d, want id=%0d prio=%0d cycle=%0d",
                   deq_id, deq_prio, cyc, m_exp[19:18], m_exp[17:16], m_exp[15:0]);
        end
      end
    end
    if (a_deq_valid) begin
      total++;
      if (age_q.size() == 0) begin
        bad++;
        $display("FAIL age_unexpected: got id=%0d prio=%0d, want no release", a_deq_id, a_deq_prio);
      end else begin
        m_exp = age_q.pop_front();
        if ({a_deq_id, a_deq_prio, cyc} !== m_exp) begin
          bad++;
          $display("FAIL age_release: got id=%0d prio=%0d cycle=%0d, want id=%0d prio=%0d cycle=%0d",
                   a_deq_id, a_deq_prio, cyc, m_exp[19:18], m_exp[17:16], m_exp[15:0]);
        end
      end
    end
    if (drop) drop_seen++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic enq(input logic [1:0] id, input logic [1:0] p);
    enq_valid = 1'b1;
    enq_id    = id;
    enq_prio  = p;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic deq(input logic [1:0] id, input logic [1:0] p);
    exp_q.push_back({id, p, cyc + 16'd1});
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
  endtask

  task automatic both(input logic [1:0] eid, input logic [1:0] ep,
                      input logic [1:0] did, input logic [1:0] dp);
    exp_q.push_back({did, dp, cyc + 16'd1});
    enq_valid = 1'b1;
    enq_id    = eid;
    enq_prio  = ep;
    deq_req   = 1'b1;
    tick();
    enq_valid = 1'b0;
    deq_req   = 1'b0;
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    enq_valid = 1'b0; enq_id = '0; enq_prio = '0; deq_req = 1'b0;
    a_enq_valid = 1'b0; a_enq_id = '0; a_enq_prio = '0; a_deq_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_drop", drop, 0);

    // baseline ordering
    enq(2'd3, 2'd0);
    enq(2'd2, 2'd2);
    check("base_count2", count, 2);
    deq(2'd2, 2'd2);
    check("base_count1", count, 1);
    deq(2'd3, 2'd0);
    tick();
    tick();
    check("hold_valid_low", deq_valid, 0);
    check("hold_id", deq_id, 3);
    check("hold_prio", deq_prio, 0);
    check("base_empty", empty, 1);

    // FIFO tie-break
    enq(2'd0, 2'd1);
    enq(2'd1, 2'd1);
    enq(2'd2, 2'd1);
    deq(2'd0, 2'd1);
    deq(2'd1, 2'd1);
    deq(2'd2, 2'd1);
    check("fifo_empty", empty, 1);
    check("fifo_count", count, 0);

    // full / drop
    enq(2'd0, 2'd1);
    enq(2'd1, 2'd2);
    enq(2'd2, 2'd0);
    enq(2'd0, 2'd3);
    check("full_flag", full, 1);
    check("full_ready", enq_ready, 0);
    check("full_count", count, 4);
    enq(2'd3, 2'd3);
    check("drop_pulse", drop, 1);
    check("drop_count", count, 4);

    // simultaneous at full: enqueue dropped, dequeue proceeds
    both(2'd3, 2'd3, 2'd0, 2'd3);
    check("simfull_drop", drop, 1);
    check("simfull_count", count, 3);
    deq(2'd1, 2'd2);
    check("drop_clear", drop, 0);
    check("sim2_pre_count", count, 2);

    // simultaneous at count 2: newcomer not eligible for the same selection
    both(2'd1, 2'd3, 2'd0, 2'd1);
    check("sim2_count", count, 2);
    deq(2'd1, 2'd3);
    deq(2'd2, 2'd0);
    check("drain_empty", empty, 1);

    // aging on the AGE_PERIOD = 4 instance
    a_enq_valid = 1'b1; a_enq_id = 2'd1; a_enq_prio = 2'd0;
    tick();
    a_enq_valid = 1'b0;
    repeat (12) tick();
    a_enq_valid = 1'b1; a_enq_id = 2'd2; a_enq_prio = 2'd2;
    tick();
    a_enq_valid = 1'b0;
    age_q.push_back({2'd1, 2'd3, cyc + 16'd1});
    a_deq_req = 1'b1;
    tick();
    age_q.push_back({2'd2, 2'd2, cyc + 16'd1});
    tick();
    a_deq_req = 1'b0;
    tick();
    check("age_empty", a_empty, 1);

    // reset mid-queue with a release pulse pending
    enq(2'd0, 2'd0);
    enq(2'd1, 2'd1);
    enq(2'd2, 2'd2);
    enq(2'd3, 2'd3);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    check("pre_rst_count", count, 3);
    rst = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_deq_valid", deq_valid, 0);
    check("rst_mid_empty", empty, 1);
    tick();
    rst = 1'b0;

    // dequeue on empty is ignored
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    check("empty_deq_count", count, 0);
    check("empty_deq_valid", deq_valid, 0);
    tick();
    tick();

    // end-of-run bookkeeping
    check("scoreboard_drained", exp_q.size(), 0);
    check("age_scoreboard_drained", age_q.size(), 0);
    check("drop_pulses", drop_seen, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
